// File: rtl/tile_pixel_shifter_if.sv
// Fetch/attribute/control inputs and the mixed dot output of the
// two-layer tile pixel shifter.
interface tile_pixel_shifter_if;
  logic       CLK_2H;
  logic       GWE;
  logic [7:0] GD;
  logic [2:0] GATTR;
  logic       LDA;
  logic       LDB;
  logic [2:0] PRI_A;
  logic [2:0] PRI_B;
  logic       FLIP;
  logic       nBLANK;
  logic [5:0] DOT;
  logic       DOT_OPAQUE;

  modport master (
    output CLK_2H, GWE, GD, GATTR, LDA, LDB, PRI_A, PRI_B, FLIP, nBLANK,
    input  DOT, DOT_OPAQUE
  );

  modport slave (
    input  CLK_2H, GWE, GD, GATTR, LDA, LDB, PRI_A, PRI_B, FLIP, nBLANK,
    output DOT, DOT_OPAQUE
  );
endinterface

// File: rtl/tile_pixel_shifter.sv
// Two-layer 2-bpp planar pixel serializer with per-layer transparency
// and priority mixing; one registered dot per pixel clock.
module tile_pixel_shifter (
  input  logic                CLK_6M,
  input  logic                rst,
  tile_pixel_shifter_if.slave bus
);

  logic [7:0] hold_a, hold_b;
  logic [2:0] hpal_a, hpal_b;
  logic [7:0] sh_a, sh_b;
  logic [2:0] spal_a, spal_b;
  logic [5:0] dot_q;
  logic       opaque_q;

  logic [1:0] cur_a, cur_b;
  logic       vis_a, vis_b;
  logic [5:0] dot_next;
  logic       opaque_next;

  // Both planes shift in lockstep inside their nibble; vacated bits fill
  // with 1 so an exhausted shifter reads as pixel 3 (transparent).
  function automatic logic [7:0] shift_nibbles(input logic [7:0] sh, input logic flip);
    if (flip)
      shift_nibbles = {1'b1, sh[7:5], 1'b1, sh[3:1]};
    else
      shift_nibbles = {sh[6:4], 1'b1, sh[2:0], 1'b1};
  endfunction

  always_comb begin
    cur_a       = bus.FLIP ? {sh_a[4], sh_a[0]} : {sh_a[7], sh_a[3]};
    cur_b       = bus.FLIP ? {sh_b[4], sh_b[0]} : {sh_b[7], sh_b[3]};
    vis_a       = (cur_a != 2'b11);
    vis_b       = (cur_b != 2'b11);
    dot_next    = 6'd0;
    opaque_next = 1'b0;
    if (bus.nBLANK) begin
      // Layer A wins ties, so it only needs PRI_A >= PRI_B to beat B.
      if (vis_a && (!vis_b || (bus.PRI_A >= bus.PRI_B))) begin
        dot_next    = {1'b0, spal_a, cur_a};
        opaque_next = 1'b1;
      end else if (vis_b) begin
        dot_next    = {1'b1, spal_b, cur_b};
        opaque_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      hold_a   <= 8'hFF;
      hold_b   <= 8'hFF;
      hpal_a   <= 3'd0;
      hpal_b   <= 3'd0;
      sh_a     <= 8'hFF;
      sh_b     <= 8'hFF;
      spal_a   <= 3'd0;
      spal_b   <= 3'd0;
      dot_q    <= 6'd0;
      opaque_q <= 1'b0;
    end else begin
      dot_q    <= dot_next;
      opaque_q <= opaque_next;

      // Loads read the pre-edge holding value, so a same-edge write lands
      // in the holding register only.
      if (bus.LDA) begin
        sh_a   <= hold_a;
        spal_a <= hpal_a;
      end else begin
        sh_a   <= shift_nibbles(sh_a, bus.FLIP);
      end

      if (bus.LDB) begin
        sh_b   <= hold_b;
        spal_b <= hpal_b;
      end else begin
        sh_b   <= shift_nibbles(sh_b, bus.FLIP);
      end

      if (bus.GWE) begin
        if (bus.CLK_2H) begin
          hold_b <= bus.GD;
          hpal_b <= bus.GATTR;
        end else begin
          hold_a <= bus.GD;
          hpal_a <= bus.GATTR;
        end
      end
    end
  end

  assign bus.DOT        = dot_q;
  assign bus.DOT_OPAQUE = opaque_q;

endmodule

// File: tb/tb_tile_pixel_shifter.sv
// Directed and randomized checks of tile_pixel_shifter against a
// pixel-array reference model.
module tb_tile_pixel_shifter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   chk_en   = 1'b0;

  tile_pixel_shifter_if bus ();

  tile_pixel_shifter dut (
    .CLK_6M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each layer is a list of four pending pixels that
  // slides toward the read end; empty slots hold transparent pixel 3.
  logic [7:0] m_hold [2];
  logic [2:0] m_hpal [2];
  logic [1:0] m_px   [2][4];
  logic [2:0] m_spal [2];
  logic [5:0] exp_dot;
  logic       exp_opq;

  always @(posedge clk) begin
    logic [1:0] cur [2];
    logic       ld  [2];
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_hold[l] = 8'hFF;
        m_hpal[l] = 3'd0;
        m_spal[l] = 3'd0;
        for (int n = 0; n < 4; n++) m_px[l][n] = 2'd3;
      end
      exp_dot = 6'd0;
      exp_opq = 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) cur[l] = bus.FLIP ? m_px[l][3] : m_px[l][0];
      exp_dot = 6'd0;
      exp_opq = 1'b0;
      if (bus.nBLANK) begin
        if (cur[0] != 2'd3 && (cur[1] == 2'd3 || bus.PRI_A >= bus.PRI_B)) begin
          exp_dot = {1'b0, m_spal[0], cur[0]};
          exp_opq = 1'b1;
        end else if (cur[1] != 2'd3) begin
          exp_dot = {1'b1, m_spal[1], cur[1]};
          exp_opq = 1'b1;
        end
      end
      ld[0] = bus.LDA;
      ld[1] = bus.LDB;
      for (int l = 0; l < 2; l++) begin
        if (ld[l]) begin
          for (int n = 0; n < 4; n++) m_px[l][n] = {m_hold[l][7-n], m_hold[l][3-n]};
          m_spal[l] = m_hpal[l];
        end else if (bus.FLIP) begin
          for (int n = 3; n > 0; n--) m_px[l][n] = m_px[l][n-1];
          m_px[l][0] = 2'd3;
        end else begin
          for (int n = 0; n < 3; n++) m_px[l][n] = m_px[l][n+1];
          m_px[l][3] = 2'd3;
        end
      end
      if (bus.GWE) begin
        m_hold[bus.CLK_2H] = bus.GD;
        m_hpal[bus.CLK_2H] = bus.GATTR;
      end
    end
  end

  // Every dot is compared against the model once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (bus.DOT !== exp_dot || bus.DOT_OPAQUE !== exp_opq) begin
        n_fails++;
        $display("[TB] FAIL cycle_model: DUT dot=%02h opq=%0d, required dot=%02h opq=%0d",
                 bus.DOT, bus.DOT_OPAQUE, exp_dot, exp_opq);
      end
    end
  end

  task automatic apply_stimulus(input logic gwe, input logic sel, input logic [7:0] gd,
                                input logic [2:0] attr, input logic lda, input logic ldb);
    bus.GWE    = gwe;
    bus.CLK_2H = sel;
    bus.GD     = gd;
    bus.GATTR  = attr;
    bus.LDA    = lda;
    bus.LDB    = ldb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  // Hand-computed expectation applied to both the DUT and the model.
  task automatic check_output(input string name, input logic [5:0] d, input logic o);
    n_checks++;
    if (bus.DOT !== d || bus.DOT_OPAQUE !== o) begin
      n_fails++;
      $display("[TB] FAIL %s: DUT dot=%02h opq=%0d, required dot=%02h opq=%0d",
               name, bus.DOT, bus.DOT_OPAQUE, d, o);
    end
    n_checks++;
    if (exp_dot !== d || exp_opq !== o) begin
      n_fails++;
      $display("[TB] FAIL %s_model: model dot=%02h opq=%0d, required dot=%02h opq=%0d",
               name, exp_dot, exp_opq, d, o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.PRI_A  = 3'd0;
    bus.PRI_B  = 3'd0;
    bus.FLIP   = 1'b0;
    bus.nBLANK = 1'b1;
    idle(2);
    chk_en = 1'b1;
    rst    = 1'b0;
    idle(1);
    check_output("reset", 6'h00, 1'b0);
    idle(4);

    // Layer A alone, FLIP=0
    apply_stimulus(1'b1, 1'b0, 8'hA6, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    idle(1); check_output("a_p0", 6'h16, 1'b1);
    idle(1); check_output("a_p1", 6'h15, 1'b1);
    idle(1); check_output("a_p2", 6'h00, 1'b0);
    idle(1); check_output("a_p3", 6'h14, 1'b1);
    idle(1); check_output("a_drained", 6'h00, 1'b0);
    idle(3);

    // Same byte with FLIP=1
    bus.FLIP = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'hA6, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    idle(1); check_output("flip_p0", 6'h14, 1'b1);
    idle(1); check_output("flip_p1", 6'h00, 1'b0);
    idle(1); check_output("flip_p2", 6'h15, 1'b1);
    idle(1); check_output("flip_p3", 6'h16, 1'b1);
    bus.FLIP = 1'b0;
    idle(5);

    // Priority: B higher, then A higher, then a tie
    bus.PRI_A = 3'd3;
    bus.PRI_B = 3'd5;
    apply_stimulus(1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h0F, 3'd2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin idle(1); check_output("pri_b_wins", 6'h29, 1'b1); end
    bus.PRI_A = 3'd5;
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin idle(1); check_output("pri_a_wins", 6'h04, 1'b1); end
    bus.PRI_A = 3'd4;
    bus.PRI_B = 3'd4;
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    idle(1); check_output("pri_tie", 6'h04, 1'b1);
    idle(5);

    // A transparent, B shows through despite lower priority
    bus.PRI_A = 3'd7;
    bus.PRI_B = 3'd0;
    apply_stimulus(1'b1, 1'b0, 8'hFF, 3'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin idle(1); check_output("fall_through", 6'h3C, 1'b1); end
    bus.PRI_A = 3'd0;
    idle(5);

    // Same-edge write and load: shifter takes the previous byte
    apply_stimulus(1'b1, 1'b0, 8'hA6, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0);
    idle(1); check_output("coll_old_p0", 6'h16, 1'b1);
    idle(1); check_output("coll_old_p1", 6'h15, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    check_output("coll_old_p2", 6'h00, 1'b0);
    idle(1); check_output("coll_new_p0", 6'h04, 1'b1);
    idle(5);

    // One blanked dot mid-byte
    apply_stimulus(1'b1, 1'b0, 8'hA6, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    idle(1); check_output("blank_p0", 6'h16, 1'b1);
    bus.nBLANK = 1'b0;
    idle(1); check_output("blank_dot", 6'h00, 1'b0);
    bus.nBLANK = 1'b1;
    idle(1); check_output("blank_p2", 6'h00, 1'b0);
    idle(1); check_output("blank_p3", 6'h14, 1'b1);
    idle(5);

    // Reset mid-stream discards buffered pixels and holding registers
    apply_stimulus(1'b1, 1'b0, 8'hA6, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    idle(1); check_output("rst_pre", 6'h16, 1'b1);
    rst = 1'b1;
    idle(1); check_output("rst_hold1", 6'h00, 1'b0);
    idle(1); check_output("rst_hold2", 6'h00, 1'b0);
    rst = 1'b0;
    idle(1); check_output("rst_after", 6'h00, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin idle(1); check_output("rst_reload", 6'h00, 1'b0); end

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.PRI_A = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.PRI_B = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) bus.FLIP = ~bus.FLIP;
      bus.nBLANK = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
